separable_conv_layer_sequencer: RTL and testbench
=================================================

SEPARABLE_CONV_LAYER_SEQUENCER -- requirements
Module: separable_conv_layer_sequencer

Interface
REQ-001 Parameter IMG_WIDHT, default 44: input frame width in pixels.
REQ-002 Parameter IMG_HEIGHT, default 44: input frame height in pixels.
REQ-003 Parameter OUT_WIDHT, default 44: output frame width produced by the separable convolution datapath.
REQ-004 Parameter OUT_HEIGHT, default 44: output frame height.
REQ-005 Parameter ADDR_W, default 12: address width; ADDR_W SHALL be at least clog2 of the larger of IMG_WIDHT*IMG_HEIGHT and OUT_WIDHT*OUT_HEIGHT.
REQ-006 Parameter TIMEOUT, default 4096: maximum idle cycles allowed in DRAIN.
REQ-007 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-008 rst  input  1  asynchronous, active-low reset.
REQ-009 start  input  1  frame start request; sampled only in IDLE.
REQ-010 hold  input  1  pauses read issue while high.
REQ-011 conv_valid_out  input  1  Valid_Out from the convolution datapath.
REQ-012 rd_en  output  1  input feature-map buffer read strobe.
REQ-013 rd_addr  output  ADDR_W  input buffer read address.
REQ-014 conv_valid_in  output  1  Valid_In to the convolution datapath.
REQ-015 wr_en  output  1  output feature-map buffer write strobe.
REQ-016 wr_addr  output  ADDR_W  output buffer write address.
REQ-017 busy  output  1  high in ISSUE or DRAIN.
REQ-018 done  output  1  one-cycle frame-complete pulse.
REQ-019 err_overrun  output  1  sticky: unexpected datapath output.
REQ-020 err_timeout  output  1  sticky: drain watchdog expired.

Function
REQ-021 FSM states SHALL be IDLE, ISSUE, DRAIN, DONE.
REQ-022 IDLE: start=1 -> ISSUE; clear in_cnt, out_cnt, err_overrun, err_timeout.
REQ-023 ISSUE: hold=0 -> rd_en=1, rd_addr=in_cnt (combinational from in_cnt), in_cnt+1; hold=1 -> rd_en=0, in_cnt held.
REQ-024 ISSUE: a read with in_cnt=IMG_WIDHT*IMG_HEIGHT-1 -> DRAIN on the next edge.
REQ-025 conv_valid_in SHALL equal rd_en delayed one cycle (one-cycle buffer read latency); rd_en SHALL be 0 outside ISSUE.
REQ-026 In ISSUE or DRAIN, conv_valid_out=1 with out_cnt below OUT_WIDHT*OUT_HEIGHT -> wr_en=1, wr_addr=out_cnt, out_cnt+1, same cycle (combinational).
REQ-027 DRAIN: out_cnt reaching OUT_WIDHT*OUT_HEIGHT -> DONE; DONE lasts one cycle with done=1, then IDLE.
REQ-028 If the final output arrives in ISSUE, the FSM SHALL still pass through DRAIN for exactly one cycle before DONE.
REQ-029 conv_valid_out=1 in IDLE or DONE, or when out_cnt already equals OUT_WIDHT*OUT_HEIGHT, SHALL set err_overrun; wr_en=0 in that cycle.
REQ-030 DRAIN: idle_cnt resets on every conv_valid_out; idle_cnt reaching TIMEOUT SHALL set err_timeout and return to IDLE with no done pulse.
REQ-031 start outside IDLE SHALL be ignored.
REQ-032 hold SHALL have no effect in DRAIN or DONE; output counting SHALL continue during hold.
REQ-033 Counters SHALL saturate, never wrap; no address beyond frame size SHALL be issued.

Reset
REQ-034 rst=0 SHALL immediately force state IDLE and in_cnt, out_cnt, idle_cnt, conv_valid_in, err_overrun, err_timeout to 0.
REQ-035 While rst=0, rd_en, rd_addr, wr_en, wr_addr, busy and done SHALL all read 0.
REQ-036 rst deasserted mid-frame SHALL abandon the frame; the next start restarts at address 0.

Verification (IMG/OUT 4x4, TIMEOUT 8)
REQ-037 start pulse, hold=0, datapath echoes conv_valid_in after 5 cycles -> rd_addr 0..15 on 16 consecutive cycles, wr_addr 0..15, one done pulse, no errors.
REQ-038 hold high for 3 cycles after address 5 -> rd_en low 3 cycles, then address 6 resumes; total 16 reads.
REQ-039 conv_valid_out pulsed in IDLE -> err_overrun=1, wr_en=0; next start clears it.
REQ-040 datapath returns only 15 outputs -> err_timeout=1 after 8 idle DRAIN cycles, no done, state IDLE.
REQ-041 rst low at read address 7 -> all outputs 0 immediately; new start reads from address 0.
REQ-042 start asserted during ISSUE and DONE -> ignored; exactly one frame processed.

Source files
------------

// File: rtl/separable_conv_layer_sequencer.sv
// Frame sequencer for a separable convolution layer: streams input-buffer reads into the
// datapath, counts returned outputs into the output buffer, and flags overrun / drain timeout.
module separable_conv_layer_sequencer #(
  parameter int unsigned IMG_WIDHT  = 44,
  parameter int unsigned IMG_HEIGHT = 44,
  parameter int unsigned OUT_WIDHT  = 44,
  parameter int unsigned OUT_HEIGHT = 44,
  parameter int unsigned ADDR_W     = 12,
  parameter int unsigned TIMEOUT    = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              hold,
  input  logic              conv_valid_out,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              conv_valid_in,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              busy,
  output logic              done,
  output logic              err_overrun,
  output logic              err_timeout
);

  localparam int unsigned CntW  = ADDR_W + 1;
  localparam int unsigned IdleW = $clog2(TIMEOUT + 1);
  localparam logic [ADDR_W-1:0] InLast  = ADDR_W'(IMG_WIDHT * IMG_HEIGHT - 1);
  localparam logic [CntW-1:0]   OutSize = CntW'(OUT_WIDHT * OUT_HEIGHT);
  localparam logic [IdleW-1:0]  IdleMax = IdleW'(TIMEOUT);

  typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] in_cnt_q, in_cnt_d;
  logic [CntW-1:0]   out_cnt_q, out_cnt_d;
  logic [IdleW-1:0]  idle_cnt_q, idle_cnt_d;
  logic              cvi_q, err_overrun_q, err_overrun_d, err_timeout_q, err_timeout_d;
  logic              active;

  always_comb begin
    active  = (state_q == StIssue) || (state_q == StDrain);
    rd_en   = (state_q == StIssue) && !hold;
    rd_addr = rd_en ? in_cnt_q : '0;
    wr_en   = conv_valid_out && active && (out_cnt_q < OutSize);
    wr_addr = wr_en ? out_cnt_q[ADDR_W-1:0] : '0;
    busy    = active;
    done    = (state_q == StDone);
  end

  assign conv_valid_in = cvi_q;
  assign err_overrun   = err_overrun_q;
  assign err_timeout   = err_timeout_q;

  always_comb begin
    state_d       = state_q;
    in_cnt_d      = in_cnt_q;
    out_cnt_d     = out_cnt_q;
    idle_cnt_d    = idle_cnt_q;
    err_overrun_d = err_overrun_q;
    err_timeout_d = err_timeout_q;
    if (wr_en) out_cnt_d = out_cnt_q + 1'b1;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d       = StIssue;
          in_cnt_d      = '0;
          out_cnt_d     = '0;
          idle_cnt_d    = '0;
          err_overrun_d = 1'b0;
          err_timeout_d = 1'b0;
        end
      end
      StIssue: begin
        // The last address holds in_cnt so no out-of-frame address is ever presented.
        if (rd_en) begin
          if (in_cnt_q == InLast) begin
            state_d    = StDrain;
            idle_cnt_d = '0;
          end else begin
            in_cnt_d = in_cnt_q + 1'b1;
          end
        end
      end
      StDrain: begin
        if (out_cnt_d == OutSize) begin
          state_d = StDone;
        end else if (conv_valid_out) begin
          idle_cnt_d = '0;
        end else if (idle_cnt_q + 1'b1 == IdleMax) begin
          state_d       = StIdle;
          idle_cnt_d    = IdleMax;
          err_timeout_d = 1'b1;
        end else begin
          idle_cnt_d = idle_cnt_q + 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    // Any datapath output that cannot be written is an overrun; set wins over the start clear.
    if (conv_valid_out && !wr_en) err_overrun_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= StIdle;
      in_cnt_q      <= '0;
      out_cnt_q     <= '0;
      idle_cnt_q    <= '0;
      cvi_q         <= 1'b0;
      err_overrun_q <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      in_cnt_q      <= in_cnt_d;
      out_cnt_q     <= out_cnt_d;
      idle_cnt_q    <= idle_cnt_d;
      cvi_q         <= rd_en;
      err_overrun_q <= err_overrun_d;
      err_timeout_q <= err_timeout_d;
    end
  end

endmodule

// File: tb/tb_separable_conv_layer_sequencer.sv
// Scoreboard bench: a 4x4 frame with a 5-cycle echo datapath model; expected read/write
// addresses are queued by the stimulus and popped by an independent negedge monitor.
module tb_separable_conv_layer_sequencer;

  localparam int unsigned AW = 4;

  logic          clk = 1'b0;
  logic          rst, start, hold, conv_valid_out, inject;
  logic          rd_en, conv_valid_in, wr_en, busy, done, err_overrun, err_timeout;
  logic [AW-1:0] rd_addr, wr_addr;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int rd_total = 0;
  int echo_limit = 16;
  int rd_q[$];
  int wr_q[$];

  logic [4:0] pipe;
  int         echoed;
  logic       echo_fire;

  separable_conv_layer_sequencer #(
    .IMG_WIDHT(4), .IMG_HEIGHT(4), .OUT_WIDHT(4), .OUT_HEIGHT(4), .ADDR_W(AW), .TIMEOUT(8)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .hold(hold), .conv_valid_out(conv_valid_out),
    .rd_en(rd_en), .rd_addr(rd_addr), .conv_valid_in(conv_valid_in), .wr_en(wr_en),
    .wr_addr(wr_addr), .busy(busy), .done(done), .err_overrun(err_overrun),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  // Datapath model: echoes conv_valid_in five cycles later, up to echo_limit outputs per frame.
  assign echo_fire      = pipe[4] && (echoed < echo_limit);
  assign conv_valid_out = echo_fire || inject;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      pipe   <= '0;
      echoed <= 0;
    end else begin
      pipe <= {pipe[3:0], conv_valid_in};
      if (start && !busy) echoed <= 0;
      else if (echo_fire) echoed <= echoed + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got event expected none", name);
  endtask

  // Monitor
  initial begin
    int exp;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (rd_en) begin
          rd_total++;
          if (rd_q.size() == 0) fail_now("rd_unexpected");
          else begin
            exp = rd_q.pop_front();
            check("rd_addr", 32'(rd_addr), 32'(exp));
          end
        end
        if (wr_en) begin
          if (wr_q.size() == 0) fail_now("wr_unexpected");
          else begin
            exp = wr_q.pop_front();
            check("wr_addr", 32'(wr_addr), 32'(exp));
          end
        end
        if (done) done_cnt++;
      end
    end
  end

  task automatic push_frame(input int nr, input int nw);
    for (int i = 0; i < nr; i++) rd_q.push_back(i);
    for (int i = 0; i < nw; i++) wr_q.push_back(i);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Returns at the negedge where done is seen.
  task automatic wait_done(input int budget);
    bit got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clk);
      if (done) got = 1'b1;
    end
    if (!got) fail_now("done_timeout");
  endtask

  task automatic wait_rd_addr(input int addr, input int budget);
    bit got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clk);
      if (rd_en && rd_addr == AW'(addr)) got = 1'b1;
    end
    if (!got) fail_now("rd_addr_wait");
  endtask

  task automatic check_queues_empty();
    check("rd_q_left", 32'(rd_q.size()), 0);
    check("wr_q_left", 32'(wr_q.size()), 0);
  endtask

  initial begin
    int rd_base;
    bit got;
    rst = 1'b0; start = 1'b0; hold = 1'b0; inject = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_rd_en", 32'(rd_en), 0);
    check("rst_rd_addr", 32'(rd_addr), 0);
    check("rst_wr_en", 32'(wr_en), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_cvi", 32'(conv_valid_in), 0);
    check("rst_ovr", 32'(err_overrun), 0);
    check("rst_tmo", 32'(err_timeout), 0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Plain frame
    rd_base = rd_total;
    push_frame(16, 16);
    pulse_start();
    check("busy_issue", 32'(busy), 1);
    wait_done(80);
    @(posedge clk); #1;
    check("done_one_cycle", 32'(done), 0);
    check("f1_done_cnt", 32'(done_cnt), 1);
    check("f1_reads", 32'(rd_total - rd_base), 16);
    check("f1_ovr", 32'(err_overrun), 0);
    check("f1_tmo", 32'(err_timeout), 0);
    check_queues_empty();

    // Overrun in IDLE, cleared by next start; that frame also exercises hold
    inject = 1'b1;
    @(negedge clk);
    check("ovr_wr_en", 32'(wr_en), 0);
    @(posedge clk); #1;
    inject = 1'b0;
    check("ovr_set", 32'(err_overrun), 1);
    rd_base = rd_total;
    push_frame(16, 16);
    pulse_start();
    check("ovr_cleared", 32'(err_overrun), 0);
    wait_rd_addr(5, 20);
    @(posedge clk); #1;
    hold = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("hold_rd_en", 32'(rd_en), 0);
    end
    @(posedge clk); #1;
    hold = 1'b0;
    wait_done(80);
    @(posedge clk); #1;
    check("f2_done_cnt", 32'(done_cnt), 2);
    check("f2_reads", 32'(rd_total - rd_base), 16);
    check("f2_ovr", 32'(err_overrun), 0);
    check_queues_empty();

    // Only 15 outputs returned: drain watchdog
    echo_limit = 15;
    push_frame(16, 15);
    pulse_start();
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (err_timeout) got = 1'b1;
    end
    if (!got) fail_now("timeout_wait");
    @(posedge clk); #1;
    check("tmo_set", 32'(err_timeout), 1);
    check("tmo_idle", 32'(busy), 0);
    check("tmo_no_done", 32'(done_cnt), 2);
    check_queues_empty();
    echo_limit = 16;

    // Reset mid-frame at read address 7
    push_frame(16, 16);
    pulse_start();
    wait_rd_addr(7, 20);
    #1 rst = 1'b0;
    #1;
    check("mid_rst_rd_en", 32'(rd_en), 0);
    check("mid_rst_rd_addr", 32'(rd_addr), 0);
    check("mid_rst_wr_en", 32'(wr_en), 0);
    check("mid_rst_wr_addr", 32'(wr_addr), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_cvi", 32'(conv_valid_in), 0);
    check("mid_rst_tmo", 32'(err_timeout), 0);
    rd_q.delete();
    wr_q.delete();
    @(posedge clk); #1;
    rst = 1'b1;
    rd_base = rd_total;
    push_frame(16, 16);
    pulse_start();
    wait_done(80);
    @(posedge clk); #1;
    check("f4_done_cnt", 32'(done_cnt), 3);
    check("f4_reads", 32'(rd_total - rd_base), 16);
    check_queues_empty();

    // start during ISSUE and DONE is ignored
    rd_base = rd_total;
    push_frame(16, 16);
    pulse_start();
    repeat (3) @(posedge clk);
    #1;
    pulse_start();
    wait_done(80);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    check("f5_idle", 32'(busy), 0);
    check("f5_done_cnt", 32'(done_cnt), 4);
    check("f5_reads", 32'(rd_total - rd_base), 16);
    check("f5_ovr", 32'(err_overrun), 0);
    check_queues_empty();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test expected finish");
    $fatal(1);
  end

endmodule
